// File: rtl/sha_alu_pkg.sv
// Shared types and helpers for the SHA ALU rotate units.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sha_alu_pkg;

  // Control states of the iterative rotator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rot_state_t;

  // (2^k) mod n, built up one doubling at a time so that the running value
  // never exceeds 2n, no matter how large k is.
  function automatic int step_amt(input int k, input int n);
    int r;
    r = 1 % n;
    for (int i = 0; i < k; i++) begin
      r = (r * 2) % n;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_circular_left.sv
// Combinational rotate-left of an N-bit value by 0..N-1 positions.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   data    : value to rotate
//   amt     : rotate amount, expected in 0..N-1
//   rotated : data rotated left by amt
module shift_circular_left #(
  parameter int N = 32
) (
  input  logic [N-1:0]         data,
  input  logic [$clog2(N)-1:0] amt,
  output logic [N-1:0]         rotated
);

  // Shifting the doubled word left and keeping its upper half brings the
  // bits that leave the MSB back in at the LSB.
  assign rotated = N'(({data, data} << amt) >> N);

endmodule

// File: rtl/shift_circular_left_iter.sv
// Multi-cycle circular left rotator: resolves one amount bit per clock.
// Latency: out_valid rises exactly B_W cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low in RUN/DONE.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake carrying a (operand), b (amount)
//   out_valid/out_ready  : result handshake carrying s = rotl(a, b mod N)
//   busy                 : high while an operation is in RUN or DONE
module shift_circular_left_iter
  import sha_alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int B_W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   s,
  output logic           busy
);

  localparam int AW = $clog2(N);
  localparam int KW = (B_W > 1) ? $clog2(B_W) : 1;

  rot_state_t     state_q;
  logic [N-1:0]   data_q;
  logic [B_W-1:0] amt_q;
  logic [KW-1:0]  k_q;

  logic [AW-1:0]  step_tab [B_W];
  logic [AW-1:0]  rot_amt;
  logic [N-1:0]   rot_data;
  logic           last_step;

  // Weight of amount bit k, already reduced mod N, so the sub-rotator only
  // ever sees amounts in 0..N-1 and b >= N folds back automatically.
  for (genvar i = 0; i < B_W; i++) begin : g_step
    assign step_tab[i] = AW'(step_amt(i, N));
  end

  always_comb begin
    rot_amt = '0;
    if (amt_q[k_q]) begin
      rot_amt = step_tab[k_q];
    end
  end

  assign last_step = (k_q == KW'(B_W - 1));

  shift_circular_left #(
    .N(N)
  ) u_rot (
    .data    (data_q),
    .amt     (rot_amt),
    .rotated (rot_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      s         <= '0;
      data_q    <= '0;
      amt_q     <= '0;
      k_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q   <= a;
            amt_q    <= b;
            k_q      <= '0;
            state_q  <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Every amount bit costs one cycle whether set or not, so the
          // latency does not depend on b.
          data_q <= rot_data;
          k_q    <= k_q + 1'b1;
          if (last_step) begin
            state_q   <= DONE;
            s         <= rot_data;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // s is left as-is on handoff; it is meaningful only with out_valid.
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
